// File: rtl/ttc_int_agg25.sv
// Interrupt aggregator for the three TTC interrupt lines. It provides pending/mask/mode
// registers and a saturating event counter through an APB window. Optional macro: TTC_INT_AGG_SYNC_EN.
`timescale 1ns/1ps
module ttc_int_agg25 #(
    parameter int         CNT_W    = 8,
    parameter logic [2:0] MODE_RST = 3'b000
) (
    input  logic        pclk25,
    input  logic        n_p_reset25,
    input  logic        psel25,
    input  logic        penable25,
    input  logic        pwrite25,
    input  logic [31:0] pwdata25,
    input  logic [7:0]  paddr25,
    input  logic [3:1]  ttc_int25,
    output logic [31:0] prdata25,
    output logic        irq25
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [2:0]       s;
    logic [2:0]       prev;
    logic [2:0]       pend;
    logic [2:0]       en;
    logic [2:0]       mode;
    logic [CNT_W-1:0] cnt;

    logic [2:0]       set_vec;
    logic [2:0]       clr_vec;
    logic [2:0]       pend_nxt;
    logic             rise;
    logic [CNT_W-1:0] cnt_nxt;

`ifdef TTC_INT_AGG_SYNC_EN
    logic [2:0] sync1;
    logic [2:0] sync2;

    always_ff @(posedge pclk25 or negedge n_p_reset25) begin
        if (!n_p_reset25) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
        end else begin
            sync1 <= ttc_int25;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = ttc_int25;
`endif

    // APB: a write commits on the access-phase edge (psel25 & penable25 & pwrite25);
    // reads are combinational whenever psel25 & ~pwrite25, with no wait states.
    logic wr;
    logic wr_pend;
    logic wr_en;
    logic wr_mode;
    logic wr_cnt;

    assign wr      = psel25 & penable25 & pwrite25;
    assign wr_pend = wr & (paddr25 == 8'h04);
    assign wr_en   = wr & (paddr25 == 8'h08);
    assign wr_mode = wr & (paddr25 == 8'h0C);
    assign wr_cnt  = wr & (paddr25 == 8'h10);

    // Edge-mode sources set only on a 0->1 of the sample. A set overrides a same-cycle W1C.
    assign set_vec  = s & (~mode | ~prev);
    assign clr_vec  = wr_pend ? pwdata25[2:0] : 3'b000;
    assign pend_nxt = (pend & ~clr_vec) | set_vec;
    assign rise     = |(pend_nxt & ~pend);

    always_comb begin
        cnt_nxt = cnt;
        if (wr_cnt) begin
            cnt_nxt = rise ? CNT_ONE : '0;
        end else if (rise && (cnt != CNT_MAX)) begin
            cnt_nxt = cnt + CNT_ONE;
        end
    end

    always_ff @(posedge pclk25 or negedge n_p_reset25) begin
        if (!n_p_reset25) begin
            prev  <= 3'b000;
            pend  <= 3'b000;
            en    <= 3'b000;
            mode  <= MODE_RST;
            cnt   <= '0;
            irq25 <= 1'b0;
        end else begin
            prev  <= s;
            pend  <= pend_nxt;
            cnt   <= cnt_nxt;
            // irq25 is registered from the current PEND and EN values. A new pending bit
            // or an EN write therefore reaches irq25 one edge after the register updates.
            irq25 <= |(pend & en);
            if (wr_en) begin
                en <= pwdata25[2:0];
            end
            if (wr_mode) begin
                mode <= pwdata25[2:0];
            end
        end
    end

    always_comb begin
        prdata25 = 32'h0;
        if (psel25 && !pwrite25) begin
            case (paddr25)
                8'h00:   prdata25[2:0]       = s;
                8'h04:   prdata25[2:0]       = pend;
                8'h08:   prdata25[2:0]       = en;
                8'h0C:   prdata25[2:0]       = mode;
                8'h10:   prdata25[CNT_W-1:0] = cnt;
                default: prdata25            = 32'h0;
            endcase
        end
    end

    logic unused_wdata;
    assign unused_wdata = ^pwdata25[31:3];

endmodule

// File: tb/tb_ttc_int_agg25.sv
// Directed bench for ttc_int_agg25 (default build): reset, level/edge modes, mask, counter, APB decode.
`timescale 1ns/1ps
module tb_ttc_int_agg25;

    logic        pclk25 = 1'b0;
    logic        n_p_reset25;
    logic        psel25;
    logic        penable25;
    logic        pwrite25;
    logic [31:0] pwdata25;
    logic [7:0]  paddr25;
    logic [3:1]  ttc_int25;
    logic [31:0] prdata25;
    logic        irq25;

    int          checks = 0;
    int          passed = 0;
    logic [31:0] rd;
    logic [31:0] exp_q[$];

    ttc_int_agg25 dut (
        .pclk25      (pclk25),
        .n_p_reset25 (n_p_reset25),
        .psel25      (psel25),
        .penable25   (penable25),
        .pwrite25    (pwrite25),
        .pwdata25    (pwdata25),
        .paddr25     (paddr25),
        .ttc_int25   (ttc_int25),
        .prdata25    (prdata25),
        .irq25       (irq25)
    );

    // clock / reset
    always #5 pclk25 = ~pclk25;

    task automatic tick;
        @(posedge pclk25);
        #1;
    endtask

    // drivers
    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        psel25    = 1'b1;
        pwrite25  = 1'b1;
        penable25 = 1'b0;
        paddr25   = a;
        pwdata25  = d;
        tick();
        penable25 = 1'b1;
        tick();
        psel25    = 1'b0;
        penable25 = 1'b0;
        pwrite25  = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        psel25    = 1'b1;
        pwrite25  = 1'b0;
        penable25 = 1'b1;
        paddr25   = a;
        #0.1;
        d         = prdata25;
        psel25    = 1'b0;
        penable25 = 1'b0;
    endtask

    task automatic test_reset;
        logic [7:0]  addrs [4];
        logic [31:0] exp;
        addrs = '{8'h04, 8'h08, 8'h0C, 8'h10};
        checks++;
        if (irq25 !== 1'b0) $display("FAIL reset_irq: got %0h expected 0", irq25);
        else passed++;
        exp_q = {32'h0, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            apb_read(addrs[i], rd);
            exp = exp_q.pop_front();
            checks++;
            if (rd !== exp) $display("FAIL reset_reg_%0h: got %0h expected %0h", addrs[i], rd, exp);
            else passed++;
        end
    endtask

    task automatic test_level;
        apb_write(8'h08, 32'h1);
        ttc_int25 = 3'b001;
        tick();
        apb_read(8'h04, rd);
        checks++;
        if (rd !== 32'h1) $display("FAIL level_pend_set: got %0h expected 1", rd);
        else passed++;
        checks++;
        if (irq25 !== 1'b0) $display("FAIL level_irq_latency: got %0h expected 0", irq25);
        else passed++;
        apb_read(8'h00, rd);
        checks++;
        if (rd !== 32'h1) $display("FAIL level_raw: got %0h expected 1", rd);
        else passed++;
        tick();
        checks++;
        if (irq25 !== 1'b1) $display("FAIL level_irq: got %0h expected 1", irq25);
        else passed++;
        // W1C while the level input is still high is immediately re-set
        apb_write(8'h04, 32'h1);
        apb_read(8'h04, rd);
        checks++;
        if (rd !== 32'h1) $display("FAIL level_w1c_held: got %0h expected 1", rd);
        else passed++;
        apb_read(8'h10, rd);
        checks++;
        if (rd !== 32'h1) $display("FAIL level_cnt: got %0h expected 1", rd);
        else passed++;
        ttc_int25 = 3'b000;
        apb_write(8'h04, 32'h1);
        tick();
        checks++;
        if (irq25 !== 1'b0) $display("FAIL level_irq_clear: got %0h expected 0", irq25);
        else passed++;
        apb_read(8'h04, rd);
        checks++;
        if (rd !== 32'h0) $display("FAIL level_pend_clear: got %0h expected 0", rd);
        else passed++;
    endtask

    task automatic test_edge;
        apb_write(8'h10, 32'h0);
        apb_write(8'h0C, 32'h2);
        apb_write(8'h08, 32'h2);
        ttc_int25 = 3'b010;
        tick();
        apb_read(8'h04, rd);
        checks++;
        if (rd !== 32'h2) $display("FAIL edge_pend_set: got %0h expected 2", rd);
        else passed++;
        repeat (4) tick();
        ttc_int25 = 3'b000;
        apb_read(8'h10, rd);
        checks++;
        if (rd !== 32'h1) $display("FAIL edge_cnt_once: got %0h expected 1", rd);
        else passed++;
        checks++;
        if (irq25 !== 1'b1) $display("FAIL edge_irq: got %0h expected 1", irq25);
        else passed++;
        apb_write(8'h04, 32'h2);
        checks++;
        if (irq25 !== 1'b1) $display("FAIL edge_irq_hold: got %0h expected 1", irq25);
        else passed++;
        tick();
        checks++;
        if (irq25 !== 1'b0) $display("FAIL edge_irq_clear: got %0h expected 0", irq25);
        else passed++;
        ttc_int25 = 3'b010;
        tick();
        apb_read(8'h10, rd);
        checks++;
        if (rd !== 32'h2) $display("FAIL edge_cnt_second: got %0h expected 2", rd);
        else passed++;
        // cleared while the input stays high: no re-set without a new rising edge
        apb_write(8'h04, 32'h2);
        repeat (3) tick();
        apb_read(8'h04, rd);
        checks++;
        if (rd !== 32'h0) $display("FAIL edge_no_reset: got %0h expected 0", rd);
        else passed++;
        apb_read(8'h10, rd);
        checks++;
        if (rd !== 32'h2) $display("FAIL edge_cnt_held: got %0h expected 2", rd);
        else passed++;
        ttc_int25 = 3'b000;
        tick();
    endtask

    task automatic test_mask;
        apb_write(8'h08, 32'h0);
        apb_write(8'h0C, 32'h0);
        ttc_int25 = 3'b111;
        tick();
        ttc_int25 = 3'b000;
        tick();
        apb_read(8'h04, rd);
        checks++;
        if (rd !== 32'h7) $display("FAIL mask_pend: got %0h expected 7", rd);
        else passed++;
        tick();
        checks++;
        if (irq25 !== 1'b0) $display("FAIL mask_irq_off: got %0h expected 0", irq25);
        else passed++;
        apb_read(8'h10, rd);
        checks++;
        if (rd !== 32'h3) $display("FAIL mask_cnt: got %0h expected 3", rd);
        else passed++;
        apb_write(8'h08, 32'h4);
        checks++;
        if (irq25 !== 1'b0) $display("FAIL en_latency: got %0h expected 0", irq25);
        else passed++;
        tick();
        checks++;
        if (irq25 !== 1'b1) $display("FAIL en_irq: got %0h expected 1", irq25);
        else passed++;
    endtask

    task automatic test_reset_mid;
        apb_write(8'h08, 32'h7);
        apb_write(8'h0C, 32'h5);
        tick();
        checks++;
        if (irq25 !== 1'b1) $display("FAIL pre_reset_irq: got %0h expected 1", irq25);
        else passed++;
        n_p_reset25 = 1'b0;
        #1;
        checks++;
        if (irq25 !== 1'b0) $display("FAIL reset_irq_async: got %0h expected 0", irq25);
        else passed++;
        apb_read(8'h04, rd);
        checks++;
        if (rd !== 32'h0) $display("FAIL reset_pend: got %0h expected 0", rd);
        else passed++;
        apb_read(8'h08, rd);
        checks++;
        if (rd !== 32'h0) $display("FAIL reset_en: got %0h expected 0", rd);
        else passed++;
        apb_read(8'h0C, rd);
        checks++;
        if (rd !== 32'h0) $display("FAIL reset_mode: got %0h expected 0", rd);
        else passed++;
        apb_read(8'h10, rd);
        checks++;
        if (rd !== 32'h0) $display("FAIL reset_cnt: got %0h expected 0", rd);
        else passed++;
        tick();
        n_p_reset25 = 1'b1;
        tick();
    endtask

    task automatic test_counter;
        // hold a PEND W1C strobe; a level input toggling each cycle yields one event per two cycles
        psel25    = 1'b1;
        penable25 = 1'b1;
        pwrite25  = 1'b1;
        paddr25   = 8'h04;
        pwdata25  = 32'h1;
        for (int i = 0; i < 400; i++) begin
            ttc_int25 = (i % 2 == 0) ? 3'b001 : 3'b000;
            tick();
        end
        psel25 = 1'b0;
        apb_read(8'h10, rd);
        checks++;
        if (rd !== 32'd200) $display("FAIL cnt_200: got %0d expected 200", rd);
        else passed++;
        psel25    = 1'b1;
        penable25 = 1'b1;
        pwrite25  = 1'b1;
        paddr25   = 8'h04;
        for (int i = 0; i < 200; i++) begin
            ttc_int25 = (i % 2 == 0) ? 3'b001 : 3'b000;
            tick();
        end
        psel25    = 1'b0;
        penable25 = 1'b0;
        pwrite25  = 1'b0;
        apb_read(8'h10, rd);
        checks++;
        if (rd !== 32'd255) $display("FAIL cnt_saturate: got %0d expected 255", rd);
        else passed++;
        psel25    = 1'b1;
        pwrite25  = 1'b1;
        penable25 = 1'b0;
        paddr25   = 8'h10;
        pwdata25  = 32'h0;
        tick();
        penable25 = 1'b1;
        ttc_int25 = 3'b001;
        tick();
        psel25    = 1'b0;
        penable25 = 1'b0;
        pwrite25  = 1'b0;
        ttc_int25 = 3'b000;
        apb_read(8'h10, rd);
        checks++;
        if (rd !== 32'h1) $display("FAIL cnt_clear_and_inc: got %0h expected 1", rd);
        else passed++;
        apb_write(8'h10, 32'h5a);
        apb_read(8'h10, rd);
        checks++;
        if (rd !== 32'h0) $display("FAIL cnt_clear: got %0h expected 0", rd);
        else passed++;
    endtask

    task automatic test_apb;
        apb_write(8'h08, 32'h7);
        apb_read(8'h08, rd);
        checks++;
        if (rd !== 32'h7) $display("FAIL en_readback: got %0h expected 7", rd);
        else passed++;
        apb_read(8'h14, rd);
        checks++;
        if (rd !== 32'h0) $display("FAIL read_0x14: got %0h expected 0", rd);
        else passed++;
        apb_read(8'hFC, rd);
        checks++;
        if (rd !== 32'h0) $display("FAIL read_0xfc: got %0h expected 0", rd);
        else passed++;
        psel25   = 1'b0;
        pwrite25 = 1'b0;
        paddr25  = 8'h08;
        #0.1;
        checks++;
        if (prdata25 !== 32'h0) $display("FAIL psel_low_prdata: got %0h expected 0", prdata25);
        else passed++;
        psel25    = 1'b1;
        pwrite25  = 1'b1;
        penable25 = 1'b0;
        paddr25   = 8'h08;
        pwdata25  = 32'h0;
        tick();
        tick();
        psel25   = 1'b0;
        pwrite25 = 1'b0;
        apb_read(8'h08, rd);
        checks++;
        if (rd !== 32'h7) $display("FAIL no_penable_write: got %0h expected 7", rd);
        else passed++;
        apb_write(8'h14, 32'h0);
        apb_read(8'h08, rd);
        checks++;
        if (rd !== 32'h7) $display("FAIL unmapped_write: got %0h expected 7", rd);
        else passed++;
    endtask

    initial begin
        n_p_reset25 = 1'b0;
        psel25      = 1'b0;
        penable25   = 1'b0;
        pwrite25    = 1'b0;
        pwdata25    = 32'h0;
        paddr25     = 8'h0;
        ttc_int25   = 3'b000;
        repeat (3) @(posedge pclk25);
        #1;
        n_p_reset25 = 1'b1;
        tick();
        test_reset();
        test_level();
        test_edge();
        test_mask();
        test_reset_mid();
        test_counter();
        test_apb();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
